// File: rtl/button_pulse_conditioner_pkg.sv
// Shared constants for the button conditioner: channel indices and debounce lengths.
package btn_pkg;

  localparam int BTN_CONFIRM = 0;
  localparam int BTN_HIGHER  = 1;
  localparam int BTN_LOWER   = 2;

  // 10 ms of stable samples at 100 MHz; the short value keeps simulations fast.
  localparam int DB_CYCLES_100MHZ_10MS = 1000000;
  localparam int DB_CYCLES_SIM         = 4;

endpackage

// File: rtl/button_pulse_conditioner_if.sv
// Button bundle between the pins/bench (master) and the conditioner (slave).
interface button_pulse_conditioner_if #(
  parameter int NUM_BTNS = 3
);

  // No handshake: btn_raw is free-running; btn_pulse is a one-cycle, at most
  // one-hot strobe that the consumer must act on in the cycle it is high.
  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_pulse;
  logic                any_pulse;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  any_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output any_pulse
  );

endinterface

// File: rtl/button_pulse_conditioner_debounce_channel.sv
// One button channel: two-flop synchroniser, consecutive-sample debounce counter,
// stable level and a combinational rise flag for the edge where the level goes 0->1.
module debounce_channel #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             s;
  logic             d;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The change is taken on the DB_CYCLES-th consecutive disagreeing sample.
  assign accept = (s != d) && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      d     <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      if (s == d) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        d   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = d;
  assign rise  = accept && s;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Debounces NUM_BTNS raw buttons and emits registered levels plus a one-hot
// press pulse, lowest channel winning when several rise on the same edge.
module button_pulse_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTNS  = 3,
  parameter int DB_CYCLES = DB_CYCLES_100MHZ_10MS,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic                        clk,
  input  logic                        reset,
  button_pulse_conditioner_if.slave   bus
);

  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] rise;
  logic [NUM_BTNS-1:0] pick;
  logic [NUM_BTNS-1:0] pulse_q;
  logic                any_q;
  logic                taken;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.btn_raw[g]),
      .level (level[g]),
      .rise  (rise[g])
    );
  end

  // Losing rises are dropped outright, so a loser needs a fresh press to pulse.
  always_comb begin
    pick  = '0;
    taken = 1'b0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (rise[i] && !taken) begin
        pick[i] = 1'b1;
        taken   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_q <= '0;
      any_q   <= 1'b0;
    end else begin
      pulse_q <= pick;
      any_q   <= |pick;
    end
  end

  assign bus.btn_level = level;
  assign bus.btn_pulse = pulse_q;
  assign bus.any_pulse = any_q;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner with DB_CYCLES=4: per-cycle scoreboard against a
// sample-history reference model, a table of press/bounce/glitch segments, and reset corners.
module tb_button_pulse_conditioner;
  import btn_pkg::*;

  localparam int N  = 3;
  localparam int DB = DB_CYCLES_SIM;

  typedef struct {
    logic [N-1:0] raw;
    int           cycles;
    logic [N-1:0] exp_level;
    int           exp_npulse;
    logic [N-1:0] exp_por;
  } seg_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [2*N:0] exp_q[$];

  button_pulse_conditioner_if #(.NUM_BTNS(N)) bus ();

  button_pulse_conditioner #(
    .NUM_BTNS  (N),
    .DB_CYCLES (DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: a level flips once the last DB synchronised samples all differ from it
  logic [N-1:0]  m_sync1, m_s, m_d;
  logic [DB-1:0] m_hist [N];

  task automatic model_edge(input logic [N-1:0] raw);
    logic [N-1:0]  nd, rise, pulse;
    logic [DB-1:0] h;
    bit            found;
    if (reset) begin
      m_sync1 = '0; m_s = '0; m_d = '0;
      for (int i = 0; i < N; i++) m_hist[i] = '0;
      exp_q.push_back('0);
      return;
    end
    nd = m_d; rise = '0; pulse = '0; found = 0;
    for (int i = 0; i < N; i++) begin
      h = {m_hist[i][DB-2:0], m_s[i]};
      m_hist[i] = h;
      if (h == {DB{~m_d[i]}}) nd[i] = ~m_d[i];
      rise[i] = nd[i] & ~m_d[i];
    end
    for (int i = 0; i < N; i++) if (rise[i] && !found) begin pulse[i] = 1'b1; found = 1; end
    m_d = nd; m_s = m_sync1; m_sync1 = raw;
    exp_q.push_back({nd, pulse, |pulse});
  endtask

  task automatic check_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_sb();
    logic [2*N:0] e, g;
    checks++;
    g = {bus.btn_level, bus.btn_pulse, bus.any_pulse};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got %b expected queue entry", g);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL sb t=%0t: got lvl=%b pul=%b any=%b expected lvl=%b pul=%b any=%b",
                 $time, g[2*N:N+1], g[N:1], g[0], e[2*N:N+1], e[N:1], e[0]);
      end
    end
  endtask

  // driver: raw is set between edges, the next edge is sampled #1 later
  task automatic step(input logic [N-1:0] raw);
    bus.btn_raw = raw;
    model_edge(raw);
    @(posedge clk);
    #1;
    check_sb();
  endtask

  task automatic measure(input logic [N-1:0] raw, input int n,
                         output int first, output int cnt, output logic [N-1:0] por);
    first = -1; cnt = 0; por = '0;
    for (int k = 0; k < n; k++) begin
      step(raw);
      if (bus.btn_pulse != 0) begin
        if (first < 0) first = k;
        cnt++;
        por |= bus.btn_pulse;
      end
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check_eq({name, "_level"}, int'(bus.btn_level), 0);
    check_eq({name, "_pulse"}, int'(bus.btn_pulse), 0);
    check_eq({name, "_any"},   int'(bus.any_pulse), 0);
  endtask

  seg_t segs[$];

  initial begin
    int           first, cnt;
    logic [N-1:0] por;
    errors = 0;
    checks = 0;
    bus.btn_raw = '0;
    reset = 1'b1;
    #1;
    check_zero_outputs("reset_async");
    step('0);
    step('0);
    reset = 1'b0;

    // clean press on higher: level and pulse first visible after edge DB+1
    measure(3'b010, 20, first, cnt, por);
    check_eq("press_first_pulse_edge", first, DB + 1);
    check_eq("press_pulse_count", cnt, 1);
    check_eq("press_pulse_vec", int'(por), 3'b010);
    check_eq("press_level_held", int'(bus.btn_level), 3'b010);
    measure(3'b000, 12, first, cnt, por);
    check_eq("release_pulse_count", cnt, 0);
    check_eq("release_level", int'(bus.btn_level), 0);

    // segment table: bounce, glitch, simultaneous press and re-press
    segs.push_back('{3'b001,  2, 3'b000, 0, 3'b000});
    segs.push_back('{3'b000,  2, 3'b000, 0, 3'b000});
    segs.push_back('{3'b001,  2, 3'b000, 0, 3'b000});
    segs.push_back('{3'b000,  2, 3'b000, 0, 3'b000});
    segs.push_back('{3'b001, 12, 3'b001, 1, 3'b001});
    segs.push_back('{3'b000,  2, 3'b001, 0, 3'b000});
    segs.push_back('{3'b001,  2, 3'b001, 0, 3'b000});
    segs.push_back('{3'b000, 12, 3'b000, 0, 3'b000});
    segs.push_back('{3'b100,  3, 3'b000, 0, 3'b000});
    segs.push_back('{3'b000, 10, 3'b000, 0, 3'b000});
    segs.push_back('{3'b110, 12, 3'b110, 1, 3'b010});
    segs.push_back('{3'b010, 10, 3'b010, 0, 3'b000});
    segs.push_back('{3'b110, 10, 3'b110, 1, 3'b100});
    segs.push_back('{3'b000, 10, 3'b000, 0, 3'b000});
    foreach (segs[r]) begin
      measure(segs[r].raw, segs[r].cycles, first, cnt, por);
      check_eq($sformatf("seg%0d_level", r), int'(bus.btn_level), int'(segs[r].exp_level));
      check_eq($sformatf("seg%0d_npulse", r), cnt, segs[r].exp_npulse);
      check_eq($sformatf("seg%0d_pulse_or", r), int'(por), int'(segs[r].exp_por));
    end

    // reset mid-debounce: partial count discarded, full latency after release
    for (int k = 0; k < 4; k++) step(3'b001);
    check_eq("middb_level_pre", int'(bus.btn_level), 0);
    reset = 1'b1;
    #1;
    check_zero_outputs("middb_reset");
    for (int k = 0; k < 3; k++) step(3'b001);
    reset = 1'b0;
    measure(3'b001, 20, first, cnt, por);
    check_eq("middb_first_pulse_edge", first, DB + 1);
    check_eq("middb_pulse_count", cnt, 1);
    check_eq("middb_pulse_vec", int'(por), 3'b001);

    // held through reset: button already accepted, then reset clears and re-presses
    reset = 1'b1;
    #1;
    check_zero_outputs("held_reset");
    for (int k = 0; k < 3; k++) step(3'b001);
    reset = 1'b0;
    measure(3'b001, 25, first, cnt, por);
    check_eq("held_first_pulse_edge", first, DB + 1);
    check_eq("held_pulse_count", cnt, 1);
    check_eq("held_level", int'(bus.btn_level), 3'b001);

    // random tail, checked by the scoreboard only
    for (int k = 0; k < 300; k++) begin
      logic [N-1:0] rv;
      rv = N'($urandom_range(0, 7));
      repeat ($urandom_range(1, 8)) step(rv);
    end
    check_eq("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
